// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, word/byte-enable widths, word alignment mask.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core data port and the memory responder.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on responses.
// master = core side (drives request and rsp_ready), slave = responder side.
interface dmem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down counter that paces the responder's wait states.
// Latency: done is decoded from the count register (no input-to-output path).
// Backpressure: n/a; counts only while en is high, stops at zero.
// Ports: clk, reset (sync, active-high), load/load_val, en, done (count == 1).
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The last wait cycle is the one where the count reads 1; the access
  // commits on the edge that ends it.
  assign done = (cnt == 4'd1);

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering core load/store requests after WAIT_CYCLES wait states.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept cycle; one request per WAIT_CYCLES+2 cycles.
// Backpressure: holds the response until rsp_ready; req_ready low outside IDLE.
// Ports: clk, reset (sync, active-high), bus (dmem_responder_if.slave).
module dmem_responder
  import mem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT4   = 4'(WAIT_CYCLES);
  // 33-bit bounds so BASE_ADDR + size cannot wrap.
  localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT33 = BASE33 + 33'(DEPTH_WORDS * 4);

  state_t            state, state_nx;
  logic              accept, commit, cnt_done;

  logic              lat_write;
  logic [WORD_W-1:0] lat_addr, lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              acc_write, acc_err;
  logic [WORD_W-1:0] acc_addr, acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [32:0]       acc_a33;
  logic [IDX_W-1:0]  acc_idx;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (WAIT4),
    .en       (state == BUSY),
    .done     (cnt_done)
  );

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (WAIT4 == 4'd0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          state_nx = BUSY;
        end
      end
      // Reset on the commit edge must leave storage untouched.
      BUSY: if (cnt_done && !reset) begin
        state_nx = RESP;
        commit   = 1'b1;
      end
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With no wait states the access happens on the accept edge itself, so the
  // live request is used; otherwise the latched copy is.
  always_comb begin
    acc_write = bus.req_write;
    acc_addr  = bus.req_addr;
    acc_wdata = bus.req_wdata;
    acc_be    = bus.req_be;
    if (state == BUSY) begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  assign acc_a33 = {1'b0, acc_addr};
  assign acc_err = ((acc_addr & ALIGN_MASK) != '0) || (acc_a33 < BASE33) || (acc_a33 >= LIMIT33);
  assign acc_idx = IDX_W'((acc_addr - BASE_ADDR) >> 2);

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (commit && acc_write && !acc_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
      end
      if (commit) begin
        rsp_rdata_q <= (!acc_write && !acc_err) ? mem[acc_idx] : '0;
        rsp_err_q   <= acc_err;
      end else if ((state == RESP) && bus.rsp_ready) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table
// plus corner-case sequences, and a WAIT_CYCLES=0 instance run back-to-back.
// Expected responses are queued when a request is driven and popped on rsp_valid.
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if if2 ();
  dmem_responder_if if0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u2 (
    .clk(clk), .reset(reset), .bus(if2));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset(reset), .bus(if0));

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vt[17];
  vec_t v0[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string nm, input logic [31:0] rd, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: response with empty scoreboard, got %h", nm, rd);
    end else begin
      e = sb.pop_front();
      check({nm, "_rdata"}, rd, e.rdata);
      check1({nm, "_err"}, er, e.err);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue2(input vec_t v, input logic rdy, input logic push);
    int   n;
    exp_t e;
    if2.req_valid = 1'b1;
    if2.req_write = v.write;
    if2.req_addr  = v.addr;
    if2.req_wdata = v.wdata;
    if2.req_be    = v.be;
    if2.rsp_ready = rdy;
    if (push) begin
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      sb.push_back(e);
    end
    n = 0;
    while (!if2.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!if2.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, addr %h", n, v.addr);
    end
    @(posedge clk);
    @(negedge clk);
    // Anything on req_* now must be ignored.
    if2.req_valid = 1'b0;
    if2.req_write = 1'($urandom);
    if2.req_addr  = $urandom;
    if2.req_wdata = $urandom;
    if2.req_be    = 4'($urandom);
  endtask

  task automatic wait_rsp2(output int lat);
    lat = 1;
    while (!if2.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!if2.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles", lat);
    end
  endtask

  task automatic run2(input vec_t v, input string nm);
    int lat;
    issue2(v, 1'b1, 1'b1);
    wait_rsp2(lat);
    check({nm, "_latency"}, lat, 32'd3);
    pop_cmp(nm, if2.rsp_rdata, if2.rsp_err);
    @(negedge clk);
    check1({nm, "_rsp_valid_cleared"}, if2.rsp_valid, 1'b0);
  endtask

  initial begin
    int   lat;
    vec_t v;

    vt[0]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 32'h020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 32'h020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vt[6]  = '{1'b0, 32'h013, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[7]  = '{1'b0, 32'h400, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[8]  = '{1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vt[9]  = '{1'b1, 32'h022, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vt[10] = '{1'b0, 32'h000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vt[11] = '{1'b0, 32'h020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[12] = '{1'b1, 32'h010, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
    vt[13] = '{1'b0, 32'h010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[14] = '{1'b1, 32'h3FC, 32'h0A0B_0C0D, 4'hF, 32'h0,         1'b0};
    vt[15] = '{1'b0, 32'h3FC, 32'h0,         4'h0, 32'h0A0B_0C0D, 1'b0};
    vt[16] = '{1'b1, 32'h008, 32'h0000_0007, 4'hF, 32'h0,         1'b0};

    v0[0]  = '{1'b1, 32'h040, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
    v0[1]  = '{1'b0, 32'h040, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    v0[2]  = '{1'b1, 32'h044, 32'h0000_0001, 4'hF, 32'h0,         1'b0};
    v0[3]  = '{1'b0, 32'h044, 32'h0,         4'h0, 32'h0000_0001, 1'b0};
    v0[4]  = '{1'b0, 32'h041, 32'h0,         4'h0, 32'h0,         1'b1};
    v0[5]  = '{1'b1, 32'h8000_0000, 32'h1,   4'hF, 32'h0,         1'b1};

    reset = 1'b1;
    if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = '0;
    if2.req_wdata = '0;   if2.req_be = '0;      if2.rsp_ready = 1'b0;
    if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0;
    if0.req_wdata = '0;   if0.req_be = '0;      if0.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_req_ready", if2.req_ready, 1'b0);
    check1("reset_rsp_valid", if2.rsp_valid, 1'b0);
    check ("reset_rsp_rdata", if2.rsp_rdata, 32'h0);
    check1("reset_rsp_err",   if2.rsp_err,   1'b0);
    reset = 1'b0;
    @(negedge clk);
    check1("idle_req_ready2", if2.req_ready, 1'b1);
    check1("idle_req_ready0", if0.req_ready, 1'b1);

    for (int i = 0; i < 17; i++) run2(vt[i], $sformatf("vec%0d", i));

    // Back-pressure: hold the response for 10 cycles, then release it while a
    // store is presented that must not be taken on the handshake cycle.
    v = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    issue2(v, 1'b0, 1'b1);
    wait_rsp2(lat);
    check("bp_latency", lat, 32'd3);
    pop_cmp("bp_first", if2.rsp_rdata, if2.rsp_err);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("bp_rsp_valid", if2.rsp_valid, 1'b1);
      check ("bp_rsp_rdata", if2.rsp_rdata, 32'hDEAD_BEEF);
      check1("bp_rsp_err",   if2.rsp_err,   1'b0);
      check1("bp_req_ready", if2.req_ready, 1'b0);
      if (i == 9) begin
        if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_addr = 32'h8;
        if2.req_wdata = 32'h0000_0BAD; if2.req_be = 4'hF;
        if2.rsp_ready = 1'b1;
      end
    end
    @(negedge clk);
    if2.req_valid = 1'b0;
    check1("bp_after_rsp_valid", if2.rsp_valid, 1'b0);
    check ("bp_after_rsp_rdata", if2.rsp_rdata, 32'h0);
    check1("bp_after_rsp_err",   if2.rsp_err,   1'b0);
    check1("bp_after_req_ready", if2.req_ready, 1'b1);

    // Reset on the would-be commit edge of a store: storage keeps the old word.
    v = '{1'b1, 32'h008, 32'h0000_0005, 4'hF, 32'h0, 1'b0};
    issue2(v, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("rstbusy_rsp_valid", if2.rsp_valid, 1'b0);
    check ("rstbusy_rsp_rdata", if2.rsp_rdata, 32'h0);
    check1("rstbusy_rsp_err",   if2.rsp_err,   1'b0);
    check1("rstbusy_req_ready", if2.req_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in RESP together with a handshake: response dropped, store kept.
    v = '{1'b1, 32'h00C, 32'h0000_0077, 4'hF, 32'h0, 1'b0};
    issue2(v, 1'b0, 1'b1);
    wait_rsp2(lat);
    pop_cmp("rstresp", if2.rsp_rdata, if2.rsp_err);
    if2.rsp_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check1("rstresp_rsp_valid", if2.rsp_valid, 1'b0);
    check1("rstresp_req_ready", if2.req_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run2('{1'b0, 32'h008, 32'h0, 4'h0, 32'h0000_0007, 1'b0}, "after_rst_ld8");
    run2('{1'b0, 32'h00C, 32'h0, 4'h0, 32'h0000_0077, 1'b0}, "after_rst_ldC");

    // Zero wait states, back-to-back, rsp_ready tied high.
    if0.rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if ((k % 2) == 0) begin
        check1("w0_req_ready", if0.req_ready, 1'b1);
        check1("w0_rsp_idle",  if0.rsp_valid, 1'b0);
        v = v0[k/2];
        if0.req_valid = 1'b1;
        if0.req_write = v.write;
        if0.req_addr  = v.addr;
        if0.req_wdata = v.wdata;
        if0.req_be    = v.be;
        sb.push_back('{v.exp_rdata, v.exp_err});
      end else begin
        check1("w0_rsp_valid",  if0.rsp_valid, 1'b1);
        check1("w0_req_busy",   if0.req_ready, 1'b0);
        pop_cmp($sformatf("w0_req%0d", k/2), if0.rsp_rdata, if0.rsp_err);
        if0.req_write = 1'($urandom);
        if0.req_addr  = $urandom;
        if0.req_wdata = $urandom;
        if0.req_be    = 4'($urandom);
      end
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    @(negedge clk);
    check1("w0_final_rsp_valid", if0.rsp_valid, 1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

endmodule
